// File: rtl/bounce_box_gen.sv
// bounce_box_gen
// Pixel-stage pattern generator placed directly after the video timing
// controller. It draws a solid BOX_SIZE x BOX_SIZE box over a background
// colour. The box moves diagonally by STEP pixels once per frame and bounces
// off the edges of the active area. The colour path is a 2-stage pipeline,
// and sync/blank are delayed by the same 2 cycles so they stay aligned with it.
//
// Ports:
//   VGA_CLK        pixel clock; all logic runs on the rising edge
//   reset          synchronous, active-high reset
//   line_value     current line from the VTC (visible lines are 0..V_ACTIVE-1)
//   pixel_location current pixel from the VTC (visible pixels are 0..H_ACTIVE-1)
//   visible_region high during active video
//   hs_in/vs_in    VTC horizontal and vertical sync
//   blank_n_in     VTC blank_n
//   pause          freezes box position and direction
//   VGA_R/G/B      colour outputs
//   VGA_HS/VS      sync outputs, 2-cycle delayed
//   VGA_BLANK_N    blank_n output, 2-cycle delayed
//   frame_tick     1-cycle pulse after each position-update event
//   bounce_count   edge bounces since reset; wraps at 16'hFFFF

module bounce_box_gen #(
    parameter int          H_ACTIVE  = 640,
    parameter int          V_ACTIVE  = 480,
    parameter int          BOX_SIZE  = 32,
    parameter int          STEP      = 2,
    parameter logic [23:0] BG_COLOR  = 24'h000040,
    parameter logic [23:0] BOX_COLOR = 24'hFFFFFF
) (
    input  logic        VGA_CLK,
    input  logic        reset,
    input  logic [15:0] line_value,
    input  logic [15:0] pixel_location,
    input  logic        visible_region,
    input  logic        hs_in,
    input  logic        vs_in,
    input  logic        blank_n_in,
    input  logic        pause,
    output logic [7:0]  VGA_R,
    output logic [7:0]  VGA_G,
    output logic [7:0]  VGA_B,
    output logic        VGA_HS,
    output logic        VGA_VS,
    output logic        VGA_BLANK_N,
    output logic        frame_tick,
    output logic [15:0] bounce_count
);

    localparam logic [16:0] H_LIM    = 17'(H_ACTIVE);
    localparam logic [16:0] V_LIM    = 17'(V_ACTIVE);
    localparam logic [16:0] BOX_W    = 17'(BOX_SIZE);
    localparam logic [16:0] STEP_W   = 17'(STEP);
    localparam logic [15:0] EVT_LINE = 16'(V_ACTIVE);

    // Advances one axis by one update event.
    // The result is packed as {bounce, new_dir, new_pos}, where dir=1 means the
    // box is moving toward larger coordinates.
    function automatic logic [17:0] axis_next(input logic [15:0] pos,
                                              input logic        dir,
                                              input logic [16:0] limit);
        logic [16:0] p;
        logic [16:0] p_n;
        logic        d_n;
        logic        b;
        p   = {1'b0, pos};
        p_n = p;
        d_n = dir;
        b   = 1'b0;
        if (dir) begin
            if ((p + BOX_W + STEP_W) > limit) begin
                p_n = limit - BOX_W;
                d_n = 1'b0;
                b   = 1'b1;
            end else begin
                p_n = p + STEP_W;
            end
        end else begin
            if (p < STEP_W) begin
                p_n = 17'd0;
                d_n = 1'b1;
                b   = 1'b1;
            end else begin
                p_n = p - STEP_W;
            end
        end
        return {b, d_n, p_n[15:0]};
    endfunction

    logic [15:0] box_x_q, box_x_d, box_y_q, box_y_d;
    logic        dir_x_q, dir_x_d, dir_y_q, dir_y_d;
    logic [15:0] bounce_count_q, bounce_count_d;
    logic        frame_tick_q, frame_tick_d;
    // stage 1
    logic        inside_q, inside_d, vis1_q, hs1_q, vs1_q, bn1_q;
    // stage 2
    logic [23:0] rgb_q, rgb_d;
    logic        hs2_q, vs2_q, bn2_q;

    logic        event_s;
    logic [17:0] nx_s, ny_s;
    logic [16:0] px_s, ly_s, bx_s, by_s;

    // Next state for motion, inside detection and colour selection
    always_comb begin
        box_x_d        = box_x_q;
        box_y_d        = box_y_q;
        dir_x_d        = dir_x_q;
        dir_y_d        = dir_y_q;
        bounce_count_d = bounce_count_q;

        event_s      = (line_value == EVT_LINE) && (pixel_location == 16'd0);
        frame_tick_d = event_s;
        nx_s         = axis_next(box_x_q, dir_x_q, H_LIM);
        ny_s         = axis_next(box_y_q, dir_y_q, V_LIM);

        // The event still produces a tick while paused; only the motion is held.
        if (event_s && !pause) begin
            box_x_d        = nx_s[15:0];
            dir_x_d        = nx_s[16];
            box_y_d        = ny_s[15:0];
            dir_y_d        = ny_s[16];
            bounce_count_d = bounce_count_q + {15'd0, nx_s[17]} + {15'd0, ny_s[17]};
        end else begin
            bounce_count_d = bounce_count_q;
        end

        // Coordinates outside the active area never count as inside the box.
        px_s     = {1'b0, pixel_location};
        ly_s     = {1'b0, line_value};
        bx_s     = {1'b0, box_x_q};
        by_s     = {1'b0, box_y_q};
        inside_d = visible_region
                   && (px_s < H_LIM) && (ly_s < V_LIM)
                   && (px_s >= bx_s) && (px_s < (bx_s + BOX_W))
                   && (ly_s >= by_s) && (ly_s < (by_s + BOX_W));

        if (inside_q) begin
            rgb_d = BOX_COLOR;
        end else if (vis1_q) begin
            rgb_d = BG_COLOR;
        end else begin
            rgb_d = 24'h000000;
        end
    end

    // State, pipeline and output registers with synchronous reset
    always_ff @(posedge VGA_CLK) begin
        if (reset) begin
            box_x_q        <= 16'd0;
            box_y_q        <= 16'd0;
            dir_x_q        <= 1'b1;
            dir_y_q        <= 1'b1;
            bounce_count_q <= 16'd0;
            frame_tick_q   <= 1'b0;
            inside_q       <= 1'b0;
            vis1_q         <= 1'b0;
            hs1_q          <= 1'b1;
            vs1_q          <= 1'b1;
            bn1_q          <= 1'b0;
            rgb_q          <= 24'h000000;
            hs2_q          <= 1'b1;
            vs2_q          <= 1'b1;
            bn2_q          <= 1'b0;
        end else begin
            box_x_q        <= box_x_d;
            box_y_q        <= box_y_d;
            dir_x_q        <= dir_x_d;
            dir_y_q        <= dir_y_d;
            bounce_count_q <= bounce_count_d;
            frame_tick_q   <= frame_tick_d;
            inside_q       <= inside_d;
            vis1_q         <= visible_region;
            hs1_q          <= hs_in;
            vs1_q          <= vs_in;
            bn1_q          <= blank_n_in;
            rgb_q          <= rgb_d;
            hs2_q          <= hs1_q;
            vs2_q          <= vs1_q;
            bn2_q          <= bn1_q;
        end
    end

    assign VGA_R        = rgb_q[23:16];
    assign VGA_G        = rgb_q[15:8];
    assign VGA_B        = rgb_q[7:0];
    assign VGA_HS       = hs2_q;
    assign VGA_VS       = vs2_q;
    assign VGA_BLANK_N  = bn2_q;
    assign frame_tick   = frame_tick_q;
    assign bounce_count = bounce_count_q;

endmodule

// File: tb/tb_bounce_box_gen.sv
// Directed testbench for bounce_box_gen. It uses three instances:
//   0: default 640x480 geometry
//   1: 64x64 area (corner bounce)
//   2: 41x480 area (odd X travel, so the box reaches x=1 and then bounces off the left edge)
// Each instance has its own line/pixel/visible inputs. Sync, blank, pause and
// reset are shared.

module tb_bounce_box_gen;

    logic        clk = 1'b0;
    logic        reset;
    logic        hs_in, vs_in, bn_in, pause;
    logic [15:0] line_v [3];
    logic [15:0] pix_v  [3];
    logic        vis_v  [3];
    logic [7:0]  r_o [3], g_o [3], b_o [3];
    logic        hs_o [3], vs_o [3], bn_o [3], tick_o [3];
    logic [15:0] bc_o [3];

    int n_vec = 0;
    int n_err = 0;
    int tick_cnt0 = 0;

    always #5 clk = ~clk;

    bounce_box_gen u_dut0 (
        .VGA_CLK(clk), .reset(reset), .line_value(line_v[0]), .pixel_location(pix_v[0]),
        .visible_region(vis_v[0]), .hs_in(hs_in), .vs_in(vs_in), .blank_n_in(bn_in),
        .pause(pause), .VGA_R(r_o[0]), .VGA_G(g_o[0]), .VGA_B(b_o[0]), .VGA_HS(hs_o[0]),
        .VGA_VS(vs_o[0]), .VGA_BLANK_N(bn_o[0]), .frame_tick(tick_o[0]), .bounce_count(bc_o[0]));

    bounce_box_gen #(.H_ACTIVE(64), .V_ACTIVE(64), .BOX_SIZE(32), .STEP(2)) u_dut1 (
        .VGA_CLK(clk), .reset(reset), .line_value(line_v[1]), .pixel_location(pix_v[1]),
        .visible_region(vis_v[1]), .hs_in(hs_in), .vs_in(vs_in), .blank_n_in(bn_in),
        .pause(pause), .VGA_R(r_o[1]), .VGA_G(g_o[1]), .VGA_B(b_o[1]), .VGA_HS(hs_o[1]),
        .VGA_VS(vs_o[1]), .VGA_BLANK_N(bn_o[1]), .frame_tick(tick_o[1]), .bounce_count(bc_o[1]));

    bounce_box_gen #(.H_ACTIVE(41), .V_ACTIVE(480), .BOX_SIZE(32), .STEP(2)) u_dut2 (
        .VGA_CLK(clk), .reset(reset), .line_value(line_v[2]), .pixel_location(pix_v[2]),
        .visible_region(vis_v[2]), .hs_in(hs_in), .vs_in(vs_in), .blank_n_in(bn_in),
        .pause(pause), .VGA_R(r_o[2]), .VGA_G(g_o[2]), .VGA_B(b_o[2]), .VGA_HS(hs_o[2]),
        .VGA_VS(vs_o[2]), .VGA_BLANK_N(bn_o[2]), .frame_tick(tick_o[2]), .bounce_count(bc_o[2]));

    // Counts frame_tick pulses from instance 0, sampled mid-cycle
    always @(negedge clk) begin
        if (tick_o[0]) tick_cnt0 = tick_cnt0 + 1;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec = n_vec + 1;
        if (obs !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Line 1000 never matches an update line, so idle instances see no event.
    task automatic idle_all();
        for (int i = 0; i < 3; i++) begin
            line_v[i] = 16'd1000;
            pix_v[i]  = 16'd5;
            vis_v[i]  = 1'b0;
        end
    endtask

    task automatic check_px(input string tag, input int idx, input int x, input int y,
                            input logic vis, input logic [23:0] exp);
        logic [23:0] rgb;
        idle_all();
        line_v[idx] = 16'(y);
        pix_v[idx]  = 16'(x);
        vis_v[idx]  = vis;
        tick();
        idle_all();
        tick();
        rgb = {r_o[idx], g_o[idx], b_o[idx]};
        check_val(tag, {8'd0, rgb}, {8'd0, exp});
    endtask

    task automatic do_events(input int idx, input int n, input int evt_line);
        for (int k = 0; k < n; k++) begin
            idle_all();
            line_v[idx] = 16'(evt_line);
            pix_v[idx]  = 16'd0;
            tick();
            idle_all();
            tick();
        end
    endtask

    localparam logic [23:0] WHITE = 24'hFFFFFF;
    localparam logic [23:0] BG    = 24'h000040;

    initial begin
        int t0;
        hs_in = 1'b1; vs_in = 1'b1; bn_in = 1'b1; pause = 1'b0;
        idle_all();
        reset = 1'b1;
        tick();
        // Hold reset for 3 cycles during active video with the sync inputs low.
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            line_v[i] = 16'd5; pix_v[i] = 16'd5; vis_v[i] = 1'b1;
        end
        hs_in = 1'b0; vs_in = 1'b0;
        tick();
        reset = 1'b1;
        tick(); tick(); tick();
        check_val("rst_rgb",   {8'd0, r_o[0], g_o[0], b_o[0]}, 32'd0);
        check_val("rst_blank", {31'd0, bn_o[0]}, 32'd0);
        check_val("rst_hs",    {31'd0, hs_o[0]}, 32'd1);
        check_val("rst_vs",    {31'd0, vs_o[0]}, 32'd1);
        check_val("rst_bc",    {16'd0, bc_o[0]}, 32'd0);
        check_val("rst_tick",  {31'd0, tick_o[0]}, 32'd0);
        hs_in = 1'b1; vs_in = 1'b1;
        idle_all();
        reset = 1'b0;

        check_px("home_px", 0, 0, 0, 1'b1, WHITE);
        check_px("blank_px", 0, 5, 5, 1'b0, 24'h000000);

        // Two consecutive pixels, plus an hs pulse that is 2 cycles wide.
        idle_all();
        line_v[0] = 16'd100; pix_v[0] = 16'd100; vis_v[0] = 1'b1; hs_in = 1'b0;
        tick();
        check_val("hs_lat1", {31'd0, hs_o[0]}, 32'd1);
        line_v[0] = 16'd10; pix_v[0] = 16'd20;
        tick();
        check_val("lat_px1", {8'd0, r_o[0], g_o[0], b_o[0]}, {8'd0, BG});
        check_val("hs_lat2", {31'd0, hs_o[0]}, 32'd0);
        idle_all(); hs_in = 1'b1;
        tick();
        check_val("lat_px2", {8'd0, r_o[0], g_o[0], b_o[0]}, {8'd0, WHITE});
        check_val("hs_lat3", {31'd0, hs_o[0]}, 32'd0);
        tick();
        check_val("hs_lat4", {31'd0, hs_o[0]}, 32'd1);

        // One event stepped by hand to check that frame_tick lasts one cycle.
        t0 = tick_cnt0;
        idle_all(); line_v[0] = 16'd480; pix_v[0] = 16'd0;
        tick();
        check_val("tick_hi", {31'd0, tick_o[0]}, 32'd1);
        idle_all();
        tick();
        check_val("tick_lo", {31'd0, tick_o[0]}, 32'd0);
        do_events(0, 4, 480);
        check_val("tick_cnt5", 32'(tick_cnt0 - t0), 32'd5);
        check_px("mv_41", 0, 41, 41, 1'b1, WHITE);
        check_px("mv_42", 0, 42, 42, 1'b1, BG);
        check_px("mv_10", 0, 10, 10, 1'b1, WHITE);
        check_px("mv_9",  0, 9, 10, 1'b1, BG);

        // While paused, the ticks keep coming but the box stays put.
        pause = 1'b1;
        t0 = tick_cnt0;
        do_events(0, 10, 480);
        pause = 1'b0;
        check_val("pause_ticks", 32'(tick_cnt0 - t0), 32'd10);
        check_px("pause_10", 0, 10, 10, 1'b1, WHITE);
        check_px("pause_9",  0, 9, 10, 1'b1, BG);
        check_px("pause_41", 0, 41, 41, 1'b1, WHITE);

        // Reach Y=448 after 224 moving events, then make the Y bounce.
        do_events(0, 219, 480);
        check_px("y448_in",  0, 448, 448, 1'b1, WHITE);
        check_px("y448_out", 0, 448, 447, 1'b1, BG);
        check_val("bc_pre_y", {16'd0, bc_o[0]}, 32'd0);
        do_events(0, 1, 480);
        check_val("bc_y", {16'd0, bc_o[0]}, 32'd1);
        check_px("ybnc_in",  0, 450, 448, 1'b1, WHITE);
        check_px("ybnc_top", 0, 450, 447, 1'b1, BG);
        check_px("ybnc_x",   0, 449, 448, 1'b1, BG);

        // Reach X=608 after 304 moving events, then make the X bounce.
        do_events(0, 79, 480);
        check_px("x608_in",  0, 608, 290, 1'b1, WHITE);
        check_px("x608_out", 0, 607, 290, 1'b1, BG);
        check_val("bc_pre_x", {16'd0, bc_o[0]}, 32'd1);
        do_events(0, 1, 480);
        check_val("bc_x", {16'd0, bc_o[0]}, 32'd2);
        check_px("xbnc_in",  0, 608, 288, 1'b1, WHITE);
        check_px("xbnc_out", 0, 607, 288, 1'b1, BG);
        do_events(0, 1, 480);
        check_px("xback_in",  0, 606, 286, 1'b1, WHITE);
        check_px("xback_out", 0, 605, 286, 1'b1, BG);
        check_px("oor_x", 0, 700, 286, 1'b1, BG);

        // Corner bounce on the 64x64 instance.
        do_events(1, 16, 64);
        check_px("c32_in",  1, 32, 32, 1'b1, WHITE);
        check_px("c32_out", 1, 31, 31, 1'b1, BG);
        check_val("c_bc_pre", {16'd0, bc_o[1]}, 32'd0);
        idle_all(); line_v[1] = 16'd64; pix_v[1] = 16'd0;
        tick();
        check_val("c_tick", {31'd0, tick_o[1]}, 32'd1);
        check_val("c_bc2", {16'd0, bc_o[1]}, 32'd2);
        idle_all();
        tick();
        check_px("cb_in",  1, 32, 32, 1'b1, WHITE);
        check_px("cb_out", 1, 31, 32, 1'b1, BG);
        do_events(1, 1, 64);
        check_px("cb_back", 1, 30, 30, 1'b1, WHITE);
        check_val("c_bc_post", {16'd0, bc_o[1]}, 32'd2);

        // 41-wide instance: x goes 2,4,6,8,9(bounce),7,5,3,1,0(bounce),2.
        do_events(2, 9, 480);
        check_px("l1_in",  2, 1, 18, 1'b1, WHITE);
        check_px("l1_out", 2, 0, 18, 1'b1, BG);
        check_val("l_bc1", {16'd0, bc_o[2]}, 32'd1);
        do_events(2, 1, 480);
        check_px("l0_in",  2, 0, 20, 1'b1, WHITE);
        check_px("l0_out", 2, 32, 20, 1'b1, BG);
        check_val("l_bc2", {16'd0, bc_o[2]}, 32'd2);
        do_events(2, 1, 480);
        check_px("l2_out", 2, 1, 22, 1'b1, BG);
        check_px("l2_in",  2, 2, 22, 1'b1, WHITE);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
